// File: rtl/vipcti_timing_pkg.sv
// Shared constants and helpers for the clocked-video timing counters.
// Used by alt_vipcti140_frame_timing_counter and its sample counter.
package vipcti_timing_pkg;

  localparam int DEF_H_WIDTH = 14;
  localparam int DEF_V_WIDTH = 13;
  localparam int DEF_SAMPLES = 1;
  localparam int DEF_LOG2_SAMPLES = 1;

  // Last valid index of a raster dimension, modulo 2^width.
  function automatic logic [31:0] last_index(
    input logic [31:0] total,
    input logic        minus_one,
    input int          width
  );
    logic [31:0] r;
    logic [31:0] mask;
    r = minus_one ? total : total - 32'd1;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return r & mask;
  endfunction

endpackage

// File: rtl/alt_vipcti140_frame_timing_counter_if.sv
// Timing-mode inputs and raster position outputs of the frame counter.
// master drives totals/controls, slave is the counter itself.
interface alt_vipcti140_frame_timing_counter_if
  import vipcti_timing_pkg::*;
#(
  parameter int H_WIDTH      = DEF_H_WIDTH,
  parameter int V_WIDTH      = DEF_V_WIDTH,
  parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
);

  logic                    sclr;
  logic                    enable;
  logic [H_WIDTH-1:0]      h_total;
  logic [V_WIDTH-1:0]      v_total;
  logic [V_WIDTH-1:0]      v_total_f1;
  logic [H_WIDTH-1:0]      h_reset;
  logic [V_WIDTH-1:0]      v_reset;
  logic                    f_reset;

  logic                    start_of_sample;
  logic [LOG2_SAMPLES-1:0] sample_tick;
  logic                    new_line;
  logic                    new_frame;
  logic [H_WIDTH-1:0]      h_count;
  logic [V_WIDTH-1:0]      v_count;
  logic                    field;

  modport master (
    output sclr, enable,
    output h_total, v_total, v_total_f1,
    output h_reset, v_reset, f_reset,
    input  start_of_sample, sample_tick,
    input  new_line, new_frame,
    input  h_count, v_count, field
  );

  modport slave (
    input  sclr, enable,
    input  h_total, v_total, v_total_f1,
    input  h_reset, v_reset, f_reset,
    output start_of_sample, sample_tick,
    output new_line, new_frame,
    output h_count, v_count, field
  );

endinterface

// File: rtl/alt_vipcti140_sample_counter.sv
// Colour-plane phase within a pixel; count_sample marks the last plane.
// SAMPLES_PER_PIXEL=1 collapses the tick to a constant zero.
module alt_vipcti140_sample_counter
  import vipcti_timing_pkg::*;
#(
  parameter int SAMPLES_PER_PIXEL = DEF_SAMPLES,
  parameter int LOG2_SAMPLES      = DEF_LOG2_SAMPLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclr,
  input  logic                    enable,
  output logic [LOG2_SAMPLES-1:0] sample_tick,
  output logic                    start_of_sample,
  output logic                    count_sample
);

  localparam logic [LOG2_SAMPLES-1:0] TICK_LAST =
    LOG2_SAMPLES'(SAMPLES_PER_PIXEL - 1);

  logic [LOG2_SAMPLES-1:0] tick_q;
  logic [LOG2_SAMPLES-1:0] tick_d;
  logic                    at_last;

  always_comb begin
    at_last = (tick_q == TICK_LAST);
    tick_d  = tick_q;
    if (sclr) begin
      tick_d = '0;
    end else if (enable) begin
      tick_d = at_last ? '0 : tick_q + LOG2_SAMPLES'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign sample_tick     = tick_q;
  assign start_of_sample = (tick_q == '0);
  assign count_sample    = enable && at_last;

endmodule

// File: rtl/alt_vipcti140_frame_timing_counter.sv
// Raster position counter: sample phase, pixel, line and field.
// Interlaced field support: define VIPCTI_FRAME_COUNTER_INTERLACE_EN.
module alt_vipcti140_frame_timing_counter
  import vipcti_timing_pkg::*;
#(
  parameter int H_WIDTH           = DEF_H_WIDTH,
  parameter int V_WIDTH           = DEF_V_WIDTH,
  parameter int SAMPLES_PER_PIXEL = DEF_SAMPLES,
  parameter int LOG2_SAMPLES      = DEF_LOG2_SAMPLES,
  parameter int TOTALS_MINUS_ONE  = 0
) (
  input logic clk,
  input logic rst_n,
  alt_vipcti140_frame_timing_counter_if.slave bus
);

  logic               count_sample;
  logic               new_line;
  logic               new_frame;
  logic               field_q;
  logic [H_WIDTH-1:0] h_last;
  logic [V_WIDTH-1:0] v_last;
  logic [V_WIDTH-1:0] v_sel;
  logic [H_WIDTH-1:0] h_count_q;
  logic [H_WIDTH-1:0] h_count_d;
  logic [V_WIDTH-1:0] v_count_q;
  logic [V_WIDTH-1:0] v_count_d;

  alt_vipcti140_sample_counter #(
    .SAMPLES_PER_PIXEL (SAMPLES_PER_PIXEL),
    .LOG2_SAMPLES      (LOG2_SAMPLES)
  ) u_sample (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclr            (bus.sclr),
    .enable          (bus.enable),
    .sample_tick     (bus.sample_tick),
    .start_of_sample (bus.start_of_sample),
    .count_sample    (count_sample)
  );

`ifdef VIPCTI_FRAME_COUNTER_INTERLACE_EN
  logic field_d;

  assign v_sel = field_q ? bus.v_total_f1 : bus.v_total;

  always_comb begin
    field_d = field_q;
    if (bus.sclr) begin
      field_d = bus.f_reset;
    end else if (new_frame) begin
      field_d = ~field_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q <= 1'b0;
    end else begin
      field_q <= field_d;
    end
  end
`else
  assign v_sel   = bus.v_total;
  assign field_q = 1'b0;
`endif

  assign h_last = H_WIDTH'(last_index(32'(bus.h_total),
                                      TOTALS_MINUS_ONE != 0,
                                      H_WIDTH));
  assign v_last = V_WIDTH'(last_index(32'(v_sel),
                                      TOTALS_MINUS_ONE != 0,
                                      V_WIDTH));

  // >= so a total shrunk below the position wraps instead of overrunning
  assign new_line  = count_sample && (h_count_q >= h_last);
  assign new_frame = new_line && (v_count_q >= v_last);

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (bus.sclr) begin
      h_count_d = bus.h_reset;
      v_count_d = bus.v_reset;
    end else if (count_sample) begin
      h_count_d = new_line ? '0 : h_count_q + H_WIDTH'(1);
      if (new_line) begin
        v_count_d = new_frame ? '0 : v_count_q + V_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign bus.new_line  = new_line;
  assign bus.new_frame = new_frame;
  assign bus.h_count   = h_count_q;
  assign bus.v_count   = v_count_q;
  assign bus.field     = field_q;

endmodule
